chord_tone_player: RTL and testbench
====================================

// Module: chord_tone_player
// PURPOSE
//   Downstream of the song sequencer. Accepts one 8-bit note mask per song line
//   through a valid/ready handshake and plays it for a fixed duration. Each set
//   bit drives a square wave on its speaker, then a short silent gap follows.
//   Mask bit map: [7]=C4 [6]=D [5]=E [4]=F [3]=G [2]=A [1]=B [0]=C5.
//   speaker1..speaker8 = bits 7..0.
// PARAMETERS
//   HP_C4  95556  half-period of C4 in clk cycles (50 MHz clock)
//   HP_D   85131  half-period of D4
//   HP_E   75843  half-period of E4
//   HP_F   71586  half-period of F4
//   HP_G   63776  half-period of G4
//   HP_A   56818  half-period of A4
//   HP_B   50619  half-period of B4
//   HP_C5  47778  half-period of C5
//   HP_W   17     width of each tone counter
//   NOTE_CYCLES  12500000  play duration (250 ms)
//   GAP_CYCLES   1250000   silence after each note; 0 = no gap
//   TMR_W  24     width of the duration timer
// PORTS
//   clk                  in   1  system clock
//   reset                in   1  synchronous, active-high reset
//   note_valid           in   1  upstream has a mask on note_mask
//   note_mask            in   8  notes to sound together; 0 = rest
//   note_ready           out  1  block can accept a mask this cycle
//   stop                 in   1  synchronous abort; silences output, returns to IDLE
//   speaker1..speaker8   out  1  square-wave outputs, one per note
//   busy                 out  1  high in PLAY or GAP
//   note_done            out  1  one-cycle pulse when a note (incl. gap) completes
// BEHAVIOUR
//   Reset: state=IDLE; all speakers, busy, note_done, counters and timer = 0.
//     Reset wins over every other input, including mid-note.
//   note_ready = (state==IDLE) & ~stop. This is combinational.
//   Accept happens on an edge where note_valid & note_ready:
//     mask is latched, tone counters and timer clear, state goes to PLAY.
//   note_mask is sampled only at accept. Later changes have no effect.
//   States: IDLE -> PLAY (accept).
//     PLAY -> GAP after NOTE_CYCLES PLAY cycles, or -> IDLE if GAP_CYCLES==0.
//     GAP -> IDLE after GAP_CYCLES cycles.
//   note_done pulses 1 cycle on the edge that enters IDLE from PLAY/GAP.
//   Tones, per lane i in PLAY:
//     cnt_i increments every cycle.
//     When cnt_i==HP_i-1: speaker_i toggles if mask bit i is set, and cnt_i -> 0.
//     The first rising edge is HP_i cycles after the accept edge.
//     Unmasked lanes stay 0.
//   On the edge leaving PLAY, every speaker is forced to 0. Speakers are 0 in GAP and IDLE.
//   Mask 0 is accepted as a rest: full PLAY+GAP timing, all speakers silent.
//   stop high at any edge: state -> IDLE, all speakers 0, timer clears, no note_done pulse.
//   stop in IDLE with note_valid: not accepted, because note_ready is low.
//   Duration is measured in whole cycles. Toggle phase is not aligned to the PLAY end.
//   Constraints: HP_i >= 2; NOTE_CYCLES >= 1; values fit HP_W/TMR_W.
//   No wrap-around can occur.
// TESTING
//   Bench uses HP_C4=4, HP_E=6, HP_G=8, HP_C5=3, NOTE_CYCLES=40, GAP_CYCLES=5,
//   other HPs=5.
//   1 Reset: hold reset 3 cycles with note_valid=1
//       -> all outputs 0; note_ready=1 only after reset drops.
//   2 Chord: accept 8'b10101000
//       -> speaker1 toggles every 4 cycles, speaker3 every 6, speaker5 every 8;
//          others stay 0.
//       -> PLAY ends 40 cycles after accept, then 5 silent cycles, then note_done pulses.
//       -> note_ready=0 throughout.
//   3 Back-to-back: note_valid held with 8'b00000001 then 8'b00000010
//       -> the second mask is accepted on the first IDLE cycle after note_done.
//       -> speaker8, then speaker7, toggle with the correct periods.
//   4 Rest: accept 8'h00 -> busy for 45 cycles, all speakers 0, note_done pulses once.
//   5 Stop: assert stop 10 cycles into PLAY
//       -> next edge: all speakers 0, IDLE, no note_done.
//       -> stop & note_valid together: no accept.
//   6 Reset mid-GAP -> IDLE, outputs 0; a new mask is accepted normally afterwards.
//       GAP_CYCLES=0 variant: PLAY -> IDLE directly with note_done.

Source files
------------

// File: rtl/chord_tone_player.sv
// chord_tone_player: accepts one 8-bit note mask per handshake and plays every
// selected note as a square wave for a fixed duration, followed by a silent gap.
// Mask bit 7 (C4) drives speaker1 down to mask bit 0 (C5) on speaker8.
module chord_tone_player #(
    parameter int unsigned HP_C4       = 95556,
    parameter int unsigned HP_D        = 85131,
    parameter int unsigned HP_E        = 75843,
    parameter int unsigned HP_F        = 71586,
    parameter int unsigned HP_G        = 63776,
    parameter int unsigned HP_A        = 56818,
    parameter int unsigned HP_B        = 50619,
    parameter int unsigned HP_C5       = 47778,
    parameter int unsigned HP_W        = 17,
    parameter int unsigned NOTE_CYCLES = 12500000,
    parameter int unsigned GAP_CYCLES  = 1250000,
    parameter int unsigned TMR_W       = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       note_valid,
    input  logic [7:0] note_mask,
    output logic       note_ready,
    input  logic       stop,
    output logic       speaker1,
    output logic       speaker2,
    output logic       speaker3,
    output logic       speaker4,
    output logic       speaker5,
    output logic       speaker6,
    output logic       speaker7,
    output logic       speaker8,
    output logic       busy,
    output logic       note_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam int unsigned NOTE_LAST = NOTE_CYCLES - 1;
    // With no gap configured the note goes straight back to IDLE.
    localparam int unsigned GAP_LAST  = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
    localparam logic [1:0]  S_AFTER_PLAY = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [TMR_W-1:0] timer;
    logic [7:0]       mask;
    logic [7:0]       spk;
    logic             accept_c;
    logic             play_hold_c;

    assign note_ready  = (state == S_IDLE) && !stop;
    assign accept_c    = note_valid && note_ready;
    // Tones run only while PLAY continues; the edge leaving PLAY silences them.
    assign play_hold_c = (state == S_PLAY) && (state_nxt == S_PLAY);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; stop overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (timer == TMR_W'(NOTE_LAST)) begin
                    state_nxt = S_AFTER_PLAY;
                end
            end
            S_GAP: begin
                if (timer == TMR_W'(GAP_LAST)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (stop) begin
            state_nxt = S_IDLE;
        end
    end

    // Duration timer, mask latch and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer     <= '0;
            mask      <= '0;
            busy      <= 1'b0;
            note_done <= 1'b0;
        end else begin
            busy      <= (state_nxt != S_IDLE);
            note_done <= (state != S_IDLE) && (state_nxt == S_IDLE) && !stop;
            if ((state == S_IDLE) || (state_nxt != state)) begin
                timer <= '0;
            end else begin
                timer <= timer + TMR_W'(1);
            end
            if (accept_c) begin
                mask <= note_mask;
            end
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_lane
        localparam int unsigned LANE_HP = (i == 7) ? HP_C4 :
                                          (i == 6) ? HP_D  :
                                          (i == 5) ? HP_E  :
                                          (i == 4) ? HP_F  :
                                          (i == 3) ? HP_G  :
                                          (i == 2) ? HP_A  :
                                          (i == 1) ? HP_B  : HP_C5;
        logic [HP_W-1:0] cnt;
        logic            tone;

        // Half-period divider; toggles the lane only when its mask bit is set.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt  <= '0;
                tone <= 1'b0;
            end else if (play_hold_c) begin
                if (cnt == HP_W'(LANE_HP - 1)) begin
                    cnt <= '0;
                    if (mask[i]) begin
                        tone <= ~tone;
                    end
                end else begin
                    cnt <= cnt + HP_W'(1);
                end
            end else begin
                cnt  <= '0;
                tone <= 1'b0;
            end
        end

        assign spk[i] = tone;
    end

    assign speaker1 = spk[7];
    assign speaker2 = spk[6];
    assign speaker3 = spk[5];
    assign speaker4 = spk[4];
    assign speaker5 = spk[3];
    assign speaker6 = spk[2];
    assign speaker7 = spk[1];
    assign speaker8 = spk[0];

endmodule

// File: tb/tb_chord_tone_player.sv
// Testbench for chord_tone_player: two instances (5-cycle gap and no gap) share
// one stimulus stream; a per-note timeline model predicts every output each cycle.
module tb_chord_tone_player;

    localparam int unsigned NOTE = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       note_valid = 1'b0;
    logic [7:0] note_mask = 8'h00;
    logic       stop = 1'b0;

    logic [7:0] spk_g, spk_z;
    logic       ready_g, ready_z, busy_g, busy_z, done_g, done_z;

    int n_pass  = 0;
    int n_total = 0;

    // Model: per instance, whether a note is running, edges since accept, latched mask.
    bit         m_act  [2];
    int         m_k    [2];
    logic [7:0] m_mask [2];
    bit         m_done [2];
    int         gap_tab [2] = '{5, 0};
    int         hp_tab  [8] = '{3, 5, 5, 8, 5, 6, 5, 4};

    always #5 clk = ~clk;

    chord_tone_player #(
        .HP_C4(4), .HP_D(5), .HP_E(6), .HP_F(5), .HP_G(8), .HP_A(5), .HP_B(5), .HP_C5(3),
        .HP_W(17), .NOTE_CYCLES(NOTE), .GAP_CYCLES(5), .TMR_W(24)
    ) dut_g (
        .clk(clk), .reset(reset), .note_valid(note_valid), .note_mask(note_mask),
        .note_ready(ready_g), .stop(stop),
        .speaker1(spk_g[7]), .speaker2(spk_g[6]), .speaker3(spk_g[5]), .speaker4(spk_g[4]),
        .speaker5(spk_g[3]), .speaker6(spk_g[2]), .speaker7(spk_g[1]), .speaker8(spk_g[0]),
        .busy(busy_g), .note_done(done_g)
    );

    chord_tone_player #(
        .HP_C4(4), .HP_D(5), .HP_E(6), .HP_F(5), .HP_G(8), .HP_A(5), .HP_B(5), .HP_C5(3),
        .HP_W(17), .NOTE_CYCLES(NOTE), .GAP_CYCLES(0), .TMR_W(24)
    ) dut_z (
        .clk(clk), .reset(reset), .note_valid(note_valid), .note_mask(note_mask),
        .note_ready(ready_z), .stop(stop),
        .speaker1(spk_z[7]), .speaker2(spk_z[6]), .speaker3(spk_z[5]), .speaker4(spk_z[4]),
        .speaker5(spk_z[3]), .speaker6(spk_z[2]), .speaker7(spk_z[1]), .speaker8(spk_z[0]),
        .busy(busy_z), .note_done(done_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one instance's note timeline by one clock edge.
    task automatic model_edge(input int d);
        m_done[d] = 1'b0;
        if (reset) begin
            m_act[d] = 1'b0;
            m_k[d]   = 0;
        end else if (stop) begin
            m_act[d] = 1'b0;
        end else if (m_act[d]) begin
            m_k[d]++;
            if (m_k[d] == NOTE + gap_tab[d]) begin
                m_act[d]  = 1'b0;
                m_done[d] = 1'b1;
            end
        end else if (note_valid) begin
            m_act[d]  = 1'b1;
            m_k[d]    = 0;
            m_mask[d] = note_mask;
        end
    endtask

    // A lane is high during the odd-numbered half-periods since accept.
    function automatic logic [7:0] exp_spk(input int d);
        logic [7:0] s;
        s = 8'h00;
        if (m_act[d] && m_k[d] < NOTE) begin
            for (int b = 0; b < 8; b++) begin
                if (m_mask[d][b] && ((m_k[d] / hp_tab[b]) % 2 == 1)) s[b] = 1'b1;
            end
        end
        return s;
    endfunction

    task automatic check_dut(input int d, input logic [7:0] spk, input logic busy,
                             input logic done, input logic ready);
        string nm;
        nm = (d == 0) ? "gap5" : "gap0";
        check({nm, " speakers"}, 32'(spk), 32'(exp_spk(d)));
        check({nm, " busy"}, 32'(busy), 32'(m_act[d]));
        check({nm, " note_done"}, 32'(done), 32'(m_done[d]));
        if (!reset) check({nm, " note_ready"}, 32'(ready), 32'(!m_act[d] && !stop));
    endtask

    task automatic tick(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_edge(0);
            model_edge(1);
            #1;
            check_dut(0, spk_g, busy_g, done_g, ready_g);
            check_dut(1, spk_z, busy_z, done_z, ready_z);
        end
    endtask

    initial begin
        // Reset held with a pending request.
        reset = 1'b1; note_valid = 1'b1; note_mask = 8'hA8;
        tick(3);
        reset = 1'b0;
        #1;
        check("ready after reset gap5", 32'(ready_g), 32'd1);
        check("ready after reset gap0", 32'(ready_z), 32'd1);

        // Chord C4+E+G; mask changes after accept must be ignored.
        tick(1);
        note_valid = 1'b0; note_mask = 8'hFF;
        tick(50);

        // Back-to-back single notes with note_valid held.
        note_valid = 1'b1; note_mask = 8'h01;
        tick(1);
        note_mask = 8'h02;
        tick(100);
        note_valid = 1'b0;
        tick(10);

        // Rest.
        note_valid = 1'b1; note_mask = 8'h00;
        tick(1);
        note_valid = 1'b0;
        tick(50);

        // Stop ten cycles into PLAY, with a request pending.
        note_valid = 1'b1; note_mask = 8'hFF;
        tick(1);
        note_valid = 1'b0;
        tick(10);
        stop = 1'b1; note_valid = 1'b1; note_mask = 8'h55;
        tick(2);
        stop = 1'b0; note_valid = 1'b0;
        tick(3);

        // Reset during GAP, then a normal note.
        note_valid = 1'b1; note_mask = 8'h81;
        tick(1);
        note_valid = 1'b0;
        tick(42);
        reset = 1'b1;
        tick(1);
        reset = 1'b0; note_valid = 1'b1; note_mask = 8'h24;
        tick(1);
        note_valid = 1'b0;
        tick(50);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            reset      = (r < 2);
            stop       = (r >= 2 && r < 8);
            note_valid = ($urandom_range(0, 3) != 0);
            note_mask  = 8'($urandom);
            tick(1);
        end
        reset = 1'b0; stop = 1'b0; note_valid = 1'b0;
        tick(50);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
